// File: rtl/nlc_ch_scheduler_if.sv
// nlc_ch_scheduler_if: channel request, NLC handshake and result bundle for the channel scheduler
interface nlc_ch_scheduler_if #(
   parameter int NCH = 16,
   parameter int CHW = 4
);
   logic [NCH-1:0]    req_i;
   logic [NCH*21-1:0] x_adc_ch_i;
   logic [NCH-1:0]    grant_o;
   logic              nlc_srdyi_o;
   logic [20:0]       nlc_x_adc_o;
   logic              nlc_srdyo_i;
   logic [20:0]       nlc_x_lin_i;
   logic              nlc_reset_o;
   logic              res_valid_o;
   logic [CHW-1:0]    res_ch_o;
   logic [20:0]       res_data_o;
   logic              busy_o;
   logic              err_timeout_o;
   modport master (
      input  req_i, x_adc_ch_i, nlc_srdyo_i, nlc_x_lin_i,
      output grant_o, nlc_srdyi_o, nlc_x_adc_o, nlc_reset_o, res_valid_o, res_ch_o, res_data_o, busy_o, err_timeout_o
   );
   modport slave (
      output req_i, x_adc_ch_i, nlc_srdyo_i, nlc_x_lin_i,
      input  grant_o, nlc_srdyi_o, nlc_x_adc_o, nlc_reset_o, res_valid_o, res_ch_o, res_data_o, busy_o, err_timeout_o
   );
endinterface

// File: rtl/nlc_ch_scheduler.sv
// nlc_ch_scheduler: round-robin sharing of one NLC among NCH ADC channels with a completion watchdog
module nlc_ch_scheduler #(
   parameter int NCH     = 16,
   parameter int CHW     = 4,
   parameter int TIMEOUT = 256
) (
   input logic                clk,
   input logic                reset,
   nlc_ch_scheduler_if.master bus
);
   localparam int CW = $clog2(TIMEOUT) + 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t         state, state_d;
   logic [CHW-1:0] ptr, ptr_d, cur_ch, cur_ch_d, sel_ch, idx, next_ch;
   logic           sel_vld;
   logic [CW-1:0]  cnt, cnt_d;
   logic [NCH-1:0] grant_q, grant_d;
   logic           srdyi_q, srdyi_d, err_q, err_d, rv_q, rv_d, busy_q;
   logic [20:0]    xadc_q, xadc_d, rdata_q, rdata_d;
   logic [CHW-1:0] rch_q, rch_d;

   assign next_ch = (cur_ch == CHW'(NCH - 1)) ? '0 : cur_ch + 1'b1;

   // rotating-priority search: the first requester at or after ptr wins
   always_comb begin
      sel_vld = 1'b0;
      sel_ch  = '0;
      idx     = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = CHW'((int'(ptr) + i) % NCH);
         if (bus.req_i[idx]) begin
            sel_vld = 1'b1;
            sel_ch  = idx;
         end
      end
   end

   // next state and next values of the registered outputs
   always_comb begin
      state_d  = state;
      ptr_d    = ptr;
      cur_ch_d = cur_ch;
      cnt_d    = cnt;
      grant_d  = '0;
      srdyi_d  = 1'b0;
      err_d    = 1'b0;
      rv_d     = 1'b0;
      xadc_d   = xadc_q;
      rdata_d  = rdata_q;
      rch_d    = rch_q;
      case (state)
         IDLE: if (sel_vld) begin
            state_d  = ISSUE;
            cur_ch_d = sel_ch;
            xadc_d   = bus.x_adc_ch_i[21*sel_ch +: 21];
            grant_d  = NCH'(1) << sel_ch;
         end
         ISSUE: begin
            state_d = WAIT;
            srdyi_d = 1'b1;
            cnt_d   = '0;
         end
         WAIT: begin
            cnt_d = cnt + 1'b1;
            if (bus.nlc_srdyo_i) begin
               state_d = DONE;
               rv_d    = 1'b1;
               rdata_d = bus.nlc_x_lin_i;
               rch_d   = cur_ch;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
               ptr_d   = next_ch;
            end
         end
         DONE: begin
            state_d = IDLE;
            ptr_d   = next_ch;
         end
         default: state_d = IDLE;
      endcase
   end

   // state, arbitration pointer, watchdog and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         cur_ch  <= '0;
         cnt     <= '0;
         grant_q <= '0;
         srdyi_q <= 1'b0;
         err_q   <= 1'b0;
         rv_q    <= 1'b0;
         busy_q  <= 1'b0;
         xadc_q  <= '0;
         rdata_q <= '0;
         rch_q   <= '0;
      end else begin
         state   <= state_d;
         ptr     <= ptr_d;
         cur_ch  <= cur_ch_d;
         cnt     <= cnt_d;
         grant_q <= grant_d;
         srdyi_q <= srdyi_d;
         err_q   <= err_d;
         rv_q    <= rv_d;
         busy_q  <= state_d != IDLE;
         xadc_q  <= xadc_d;
         rdata_q <= rdata_d;
         rch_q   <= rch_d;
      end
   end

   assign bus.grant_o       = grant_q;
   assign bus.nlc_srdyi_o   = srdyi_q;
   assign bus.nlc_x_adc_o   = xadc_q;
   assign bus.nlc_reset_o   = reset | err_q;
   assign bus.res_valid_o   = rv_q;
   assign bus.res_ch_o      = rch_q;
   assign bus.res_data_o    = rdata_q;
   assign bus.busy_o        = busy_q;
   assign bus.err_timeout_o = err_q;
endmodule
